// File: rtl/sram_pkg.sv
// +--------------------------------------------------------------------+
// | sram_pkg : shared constants and arbiter state encoding             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package sram_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/sram_rr_pick.sv
// +--------------------------------------------------------------------+
// | sram_rr_pick : 2-way round-robin picker, favours the client not     |
// | served last on a tie.  Rev 1.0                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module sram_rr_pick (
  input  logic req_0_i,
  input  logic req_1_i,
  input  logic last_i,
  output logic sel_o,
  output logic valid_o
);

  assign valid_o = req_0_i | req_1_i;
  assign sel_o   = (req_0_i & req_1_i) ? ~last_i : req_1_i;

endmodule

`default_nettype wire

// File: rtl/sram_port_arbiter.sv
// +--------------------------------------------------------------------+
// | sram_port_arbiter : shares the SRAM controller command port        |
// | between two clients with round-robin arbitration.  Rev 1.0         |
// +--------------------------------------------------------------------+
`default_nettype none

module sram_port_arbiter #(
  parameter int ADDR_W      = sram_pkg::ADDR_W,
  parameter int DATA_W      = sram_pkg::DATA_W,
  parameter int MIN_WAIT    = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_0,
  input  logic              rw_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic              req_1,
  input  logic              rw_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              gnt_0,
  output logic              gnt_1,
  output logic              done_0,
  output logic              done_1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic              mem,
  output logic              rw,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_f2s,
  input  logic              ready,
  input  logic [DATA_W-1:0] data_s2f_r
);

  import sram_pkg::*;

  localparam int               CNT_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] WAIT_MIN  = CNT_W'(MIN_WAIT);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_SAT  = CNT_W'(TIMEOUT_CYC);

  arb_state_t        state_q;
  logic              client_q;
  logic              last_q;
  logic              abort_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              gnt_0_q, gnt_1_q, done_0_q, done_1_q, err_q, busy_q, mem_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rdata_q;
  logic              pick_sel;
  logic              pick_valid;

  sram_rr_pick u_pick (
    .req_0_i (req_0),
    .req_1_i (req_1),
    .last_i  (last_q),
    .sel_o   (pick_sel),
    .valid_o (pick_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      client_q <= 1'b0;
      last_q   <= 1'b1;
      abort_q  <= 1'b0;
      cnt_q    <= '0;
      gnt_0_q  <= 1'b0;
      gnt_1_q  <= 1'b0;
      done_0_q <= 1'b0;
      done_1_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      mem_q    <= 1'b0;
      rw_q     <= RW_READ;
      addr_q   <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
    end else begin
      gnt_0_q  <= 1'b0;
      gnt_1_q  <= 1'b0;
      done_0_q <= 1'b0;
      done_1_q <= 1'b0;
      err_q    <= 1'b0;
      mem_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ready && pick_valid) begin
            client_q <= pick_sel;
            rw_q     <= pick_sel ? rw_1    : rw_0;
            addr_q   <= pick_sel ? addr_1  : addr_0;
            data_q   <= pick_sel ? wdata_1 : wdata_0;
            gnt_0_q  <= ~pick_sel;
            gnt_1_q  <= pick_sel;
            busy_q   <= 1'b1;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_q   <= 1'b1;
          cnt_q   <= '0;
          abort_q <= 1'b0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_q != WAIT_SAT) cnt_q <= cnt_q + 1'b1;
          // A late ready on the final counted cycle still wins over the abort.
          if (cnt_q >= WAIT_MIN && ready) begin
            state_q <= ST_DONE;
          end else if (cnt_q >= WAIT_LAST) begin
            abort_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_0_q <= ~client_q;
          done_1_q <= client_q;
          err_q    <= abort_q;
          if (rw_q == RW_READ && !abort_q) rdata_q <= data_s2f_r;
          last_q   <= client_q;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt_0    = gnt_0_q;
  assign gnt_1    = gnt_1_q;
  assign done_0   = done_0_q;
  assign done_1   = done_1_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign mem      = mem_q;
  assign rw       = rw_q;
  assign addr     = addr_q;
  assign data_f2s = data_q;
  assign rdata    = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_sram_port_arbiter : scoreboard bench with a transaction-level    |
// | arbiter model and a behavioural SRAM controller.  Rev 1.0          |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_sram_port_arbiter;

  localparam int AW       = 19;
  localparam int DW       = 8;
  localparam int MIN_WAIT = 2;
  localparam int TMO      = 64;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_0 = 1'b0, rw_0 = 1'b1, req_1 = 1'b0, rw_1 = 1'b1;
  logic [AW-1:0] addr_0 = '0, addr_1 = '0;
  logic [DW-1:0] wdata_0 = '0, wdata_1 = '0;
  logic          ready = 1'b1;
  logic [DW-1:0] data_s2f_r = '0;
  logic          gnt_0, gnt_1, done_0, done_1, err, busy, mem, rw;
  logic [DW-1:0] rdata, data_f2s;
  logic [AW-1:0] addr;

  sram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MIN_WAIT(MIN_WAIT), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_0(req_0), .rw_0(rw_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .req_1(req_1), .rw_1(rw_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .done_0(done_0), .done_1(done_1),
    .rdata(rdata), .err(err), .busy(busy), .mem(mem), .rw(rw), .addr(addr),
    .data_f2s(data_f2s), .ready(ready), .data_s2f_r(data_s2f_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            client;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            err;
    int            lat;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  int checks = 0;
  int errors = 0;

  // Transaction-level model state
  bit            last_srv = 1'b1;
  logic [DW-1:0] model_rdata = '0;
  logic [DW-1:0] refmem [logic [AW-1:0]];

  // Behavioural controller state
  logic [DW-1:0] cmem [logic [AW-1:0]];
  int            ctrl_d = 0;
  bit            ctrl_stall = 1'b0;
  bit            ctrl_kill = 1'b0;
  int            ccnt = 0;
  logic          c_rw = 1'b1;
  logic [AW-1:0] c_addr = '0;
  bit            c_stall = 1'b0;

  int cyc = 0;
  int gnt_cyc = -100;
  int mem_cyc = -100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] crd(input logic [AW-1:0] a);
    return cmem.exists(a) ? cmem[a] : 8'h00;
  endfunction

  function automatic logic [DW-1:0] mrd(input logic [AW-1:0] a);
    return refmem.exists(a) ? refmem[a] : 8'h00;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom % 4)
      0:       return 19'h00ABC;
      1:       return 19'h7FFFF;
      2:       return 19'h00000;
      default: return 19'h12345;
    endcase
  endfunction

  task automatic do_txn(input logic [1:0] pat,
                        input logic r0, input logic [AW-1:0] a0, input logic [DW-1:0] w0,
                        input logic r1, input logic [AW-1:0] a1, input logic [DW-1:0] w1,
                        input int d, input bit stall, input bit abort_mid);
    exp_t x;
    bit   got;
    bit   rdy0;
    int   wt;
    x.client = (pat == 2'b11) ? ~last_srv : pat[1];
    x.rw     = x.client ? r1 : r0;
    x.addr   = x.client ? a1 : a0;
    x.wdata  = x.client ? w1 : w0;
    x.err    = stall;
    x.lat    = stall ? TMO + 1 : ((d > MIN_WAIT) ? d : MIN_WAIT) + 2;
    if (!stall && !abort_mid) begin
      if (x.rw) model_rdata = mrd(x.addr);
      else      refmem[x.addr] = x.wdata;
    end
    x.rdata = model_rdata;
    if (!abort_mid) last_srv = x.client;
    exp_q.push_back(x);
    ctrl_d = d;
    ctrl_stall = stall;
    req_0 = pat[0]; rw_0 = r0; addr_0 = a0; wdata_0 = w0;
    req_1 = pat[1]; rw_1 = r1; addr_1 = a1; wdata_1 = w1;
    rdy0 = ready;
    got = 1'b0;
    wt = 0;
    while (!got && wt < 300) begin
      @(negedge clk);
      wt++;
      got = gnt_0 | gnt_1;
    end
    req_0 = 1'b0; req_1 = 1'b0;
    addr_0 = AW'($urandom); addr_1 = AW'($urandom);
    wdata_0 = DW'($urandom); wdata_1 = DW'($urandom);
    rw_0 = ~r0; rw_1 = ~r1;
    if (!got) begin
      chk("gnt_wait_timeout", 32'd0, 32'd1);
      exp_q.delete();
      return;
    end
    if (rdy0) chk("gnt_latency", 32'(wt), 32'd1);
    if (abort_mid) begin
      @(negedge clk);
      #1 reset_n = 1'b0;
      ctrl_kill = 1'b1;
      #1;
      chk("reset_mem_drop", 32'(mem), 32'd0);
      chk("reset_busy_drop", 32'(busy), 32'd0);
      exp_q.delete();
      last_srv = 1'b1;
      model_rdata = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      ctrl_kill = 1'b0;
      repeat (10) @(negedge clk);
      return;
    end
    got = 1'b0;
    wt = 0;
    while (!got && wt < 300) begin
      @(negedge clk);
      wt++;
      got = done_0 | done_1;
    end
    if (!got) begin
      chk("done_wait_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
  endtask

  initial begin
    fork
      // Scoreboard monitor
      forever begin
        @(negedge clk);
        cyc++;
        if (reset_n) begin
          if (gnt_0 | gnt_1) begin
            gnt_cyc = cyc;
            if (exp_q.size() == 0) chk("spurious_gnt", 32'({gnt_1, gnt_0}), 32'd0);
            else chk("gnt_client", 32'({gnt_1, gnt_0}), exp_q[0].client ? 32'd2 : 32'd1);
          end
          if (mem) begin
            mem_cyc = cyc;
            chk("mem_after_gnt", 32'(cyc - gnt_cyc), 32'd1);
            if (exp_q.size() == 0) chk("spurious_mem", 32'(mem), 32'd0);
            else begin
              chk("mem_rw", 32'(rw), 32'(exp_q[0].rw));
              chk("mem_addr", 32'(addr), 32'(exp_q[0].addr));
              chk("mem_data", 32'(data_f2s), 32'(exp_q[0].wdata));
              chk("mem_busy", 32'(busy), 32'd1);
            end
          end
          if (done_0 | done_1) begin
            if (exp_q.size() == 0) chk("spurious_done", 32'({done_1, done_0}), 32'd0);
            else begin
              e = exp_q.pop_front();
              chk("done_client", 32'({done_1, done_0}), e.client ? 32'd2 : 32'd1);
              chk("done_err", 32'(err), 32'(e.err));
              chk("done_latency", 32'(cyc - mem_cyc), 32'(e.lat));
              chk("done_rdata", 32'(rdata), 32'(e.rdata));
              chk("done_busy", 32'(busy), 32'd0);
            end
          end else if (err) begin
            chk("err_without_done", 32'(err), 32'd0);
          end
        end
      end
      // Behavioural SRAM controller
      forever begin
        @(negedge clk);
        if (ctrl_kill) begin
          ccnt = 0;
          ready = 1'b1;
        end else if (ccnt > 0) begin
          ccnt--;
          if (ccnt == 0) begin
            ready = 1'b1;
            if (c_rw && !c_stall) data_s2f_r = crd(c_addr);
          end else begin
            data_s2f_r = DW'($urandom);
          end
        end
        if (mem && reset_n && !ctrl_kill) begin
          c_rw = rw;
          c_addr = addr;
          c_stall = ctrl_stall;
          if (!rw && !ctrl_stall) cmem[addr] = data_f2s;
          ccnt = ctrl_stall ? 80 : ctrl_d;
          if (ccnt == 0) begin
            if (rw) data_s2f_r = crd(addr);
          end else begin
            ready = 1'b0;
            data_s2f_r = DW'($urandom);
          end
        end
      end
    join_none

    // Reset state with a request pending
    req_0 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mem", 32'(mem), 32'd0);
    chk("rst_gnt", 32'({gnt_1, gnt_0}), 32'd0);
    chk("rst_done", 32'({done_1, done_0}), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rw", 32'(rw), 32'd1);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_data_f2s", 32'(data_f2s), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    req_0 = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);

    // Directed write then read-back
    do_txn(2'b10, 1'b1, 19'h0, 8'h00, 1'b0, 19'h00ABC, 8'h5A, 0, 1'b0, 1'b0);
    do_txn(2'b01, 1'b1, 19'h00ABC, 8'h00, 1'b1, 19'h0, 8'h00, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rdata_hold", 32'(rdata), 32'h5A);

    // Contention
    repeat (4) do_txn(2'b11, 1'($urandom), rand_addr(), DW'($urandom),
                      1'($urandom), rand_addr(), DW'($urandom), 1, 1'b0, 1'b0);

    // Timeout on a read: rdata must keep its old value
    do_txn(2'b01, 1'b1, 19'h00ABC, 8'h00, 1'b1, 19'h0, 8'h00, 0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      do_txn(2'($urandom_range(1, 3)),
             1'($urandom), rand_addr(), DW'($urandom),
             1'($urandom), rand_addr(), DW'($urandom),
             int'($urandom_range(0, 6)), ($urandom % 16) == 0, 1'b0);
    end

    // Reset during WAIT, then a tie must go to client 0
    do_txn(2'b10, 1'b1, 19'h0, 8'h00, 1'b1, 19'h00ABC, 8'h00, 3, 1'b0, 1'b1);
    do_txn(2'b11, 1'b1, 19'h00ABC, 8'h00, 1'b0, 19'h12345, 8'hC3, 0, 1'b0, 1'b0);
    do_txn(2'b11, 1'b1, 19'h12345, 8'h00, 1'b0, 19'h00000, 8'h11, 2, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
